// File: rtl/block_refill_responder.sv
// -----------------------------------------------------------------------------
// block_refill_responder
//
// Memory-side end of the cache miss path. Accepts one block refill request at
// a time, reads the aligned block out of a fixed-latency block RAM one byte
// per cycle, and streams the bytes back to the cache in offset order.
//
// State table
//   state | meaning
//   IDLE  | ready for a request; req_ready_o high
//   ISSUE | one RAM read per cycle, base .. base+N-1
//   DRAIN | reads issued; waiting for the final beat to leave
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_addr_i               faulting byte address (block offset bits ignored)
//   ram_en_o, ram_addr_o     block RAM read port
//   ram_rdata_i              RAM data, RAM_RD_LATENCY cycles after ram_en_o
//   rsp_valid_o, rsp_data_o  refill beat (no backpressure)
//   rsp_offset_o, rsp_last_o beat offset within block, final-beat flag
//   refill_count_o           completed refills, saturating
// -----------------------------------------------------------------------------
module block_refill_responder #(
    parameter int ADDR_WIDTH        = 16,
    parameter int BLOCK_OFFSET_BITS = 2,
    parameter int DATA_WIDTH        = 8,
    parameter int RAM_RD_LATENCY    = 2,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    output logic                         ram_en_o,
    output logic [ADDR_WIDTH-1:0]        ram_addr_o,
    input  logic [DATA_WIDTH-1:0]        ram_rdata_i,
    output logic                         rsp_valid_o,
    output logic [DATA_WIDTH-1:0]        rsp_data_o,
    output logic [BLOCK_OFFSET_BITS-1:0] rsp_offset_o,
    output logic                         rsp_last_o,
    output logic [COUNT_WIDTH-1:0]       refill_count_o
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);
    localparam logic [BLOCK_OFFSET_BITS-1:0] LAST_OFFSET = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                         state_q;
    logic                           req_ready_q;
    logic                           ram_en_q;
    logic [ADDR_WIDTH-1:0]          ram_addr_q;
    logic [COUNT_WIDTH-1:0]         count_q;

    logic [RAM_RD_LATENCY-1:0]      vld_pipe_q;
    logic [BLOCK_OFFSET_BITS-1:0]   off_pipe_q [RAM_RD_LATENCY];
    logic                           rsp_valid_q;
    logic [DATA_WIDTH-1:0]          rsp_data_q;
    logic [BLOCK_OFFSET_BITS-1:0]   rsp_offset_q;
    logic                           rsp_last_q;

    logic [ADDR_WIDTH-1:0]          base_d;

    assign base_d = req_addr_i & ~OFFSET_MASK;

    // Control FSM. ram_addr_q doubles as the issue counter: the base is
    // aligned, so its low bits are the beat index of the read in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= ISSUE;
                        req_ready_q <= 1'b0;
                        ram_en_q    <= 1'b1;
                        ram_addr_q  <= base_d;
                    end
                end
                ISSUE: begin
                    if (ram_addr_q[BLOCK_OFFSET_BITS-1:0] == LAST_OFFSET) begin
                        state_q  <= DRAIN;
                        ram_en_q <= 1'b0;
                    end else begin
                        ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Final beat is on the outputs this cycle; done next cycle.
                    if (rsp_last_q) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        if (count_q != '1) begin
                            count_q <= count_q + COUNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Return path: valid/offset travel alongside the RAM latency so each
    // returning byte knows its beat index. Reset clears in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q   <= '0;
            for (int k = 0; k < RAM_RD_LATENCY; k++) begin
                off_pipe_q[k] <= '0;
            end
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_offset_q <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            vld_pipe_q[0] <= ram_en_q;
            off_pipe_q[0] <= ram_addr_q[BLOCK_OFFSET_BITS-1:0];
            for (int k = 1; k < RAM_RD_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                off_pipe_q[k] <= off_pipe_q[k-1];
            end
            rsp_valid_q <= vld_pipe_q[RAM_RD_LATENCY-1];
            rsp_last_q  <= vld_pipe_q[RAM_RD_LATENCY-1] &&
                           (off_pipe_q[RAM_RD_LATENCY-1] == LAST_OFFSET);
            if (vld_pipe_q[RAM_RD_LATENCY-1]) begin
                rsp_data_q   <= ram_rdata_i;
                rsp_offset_q <= off_pipe_q[RAM_RD_LATENCY-1];
            end
        end
    end

    assign req_ready_o    = req_ready_q;
    assign ram_en_o       = ram_en_q;
    assign ram_addr_o     = ram_addr_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_offset_o   = rsp_offset_q;
    assign rsp_last_o     = rsp_last_q;
    assign refill_count_o = count_q;

endmodule

// File: tb/tb_block_refill_responder.sv
// -----------------------------------------------------------------------------
// Bench for block_refill_responder. A second instance with a 2-bit refill
// counter shares all inputs so counter saturation is reachable quickly.
// The reference model tracks each refill by its handshake cycle c0 and derives
// every output from the cycle distance d = cycle - c0.
// -----------------------------------------------------------------------------
module tb_block_refill_responder;

    localparam int N = 4;
    localparam int L = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic [7:0]  ram_rdata;

    logic        req_ready, ram_en, rsp_valid, rsp_last;
    logic [15:0] ram_addr, refill_count;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_offset;

    logic        s_ready, s_en, s_valid, s_last;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    logic [1:0]  s_offset;
    logic [1:0]  s_count;

    block_refill_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_rdata_i(ram_rdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_offset_o(rsp_offset),
        .rsp_last_o(rsp_last), .refill_count_o(refill_count)
    );

    block_refill_responder #(.COUNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(s_ready), .req_addr_i(req_addr),
        .ram_en_o(s_en), .ram_addr_o(s_addr), .ram_rdata_i(ram_rdata),
        .rsp_valid_o(s_valid), .rsp_data_o(s_data), .rsp_offset_o(s_offset),
        .rsp_last_o(s_last), .refill_count_o(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;

    // model state
    logic        act    = 1'b0;
    int          c0     = 0;
    logic [15:0] base   = '0;
    int          mcount = 0;
    logic [15:0] hist [0:L];

    function automatic logic [7:0] ramf(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    // One cycle: RAM model, compare all outputs with the model, then drive
    // the inputs for this cycle and update the model for the coming edge.
    task automatic step(input logic v, input logic [15:0] a, input logic r);
        int          d, off;
        logic        e_ready, e_en, e_rv, e_last;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        @(negedge clk);
        cyc++;
        for (int k = L; k > 0; k--) hist[k] = hist[k-1];
        hist[0]   = ram_addr;
        ram_rdata = ramf(hist[L]);

        d       = cyc - c0;
        e_ready = !act;
        e_en    = act && d >= 1 && d <= N;
        e_addr  = base + 16'(d - 1);
        e_rv    = act && d >= L + 2 && d <= L + 1 + N;
        off     = d - L - 2;
        e_last  = e_rv && off == N - 1;
        e_data  = ramf(base + 16'(off));

        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("ram_en", 32'(ram_en), 32'(e_en));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_last", 32'(rsp_last), 32'(e_last));
        check("refill_count", 32'(refill_count), 32'(mcount));
        check("sat_ready", 32'(s_ready), 32'(e_ready));
        check("sat_en", 32'(s_en), 32'(e_en));
        check("sat_valid", 32'(s_valid), 32'(e_rv));
        check("sat_last", 32'(s_last), 32'(e_last));
        check("sat_count", 32'(s_count), 32'((mcount > 3) ? 3 : mcount));
        if (e_en) begin
            check("ram_addr", 32'(ram_addr), 32'(e_addr));
            check("sat_addr", 32'(s_addr), 32'(e_addr));
        end
        if (e_rv) begin
            check("rsp_data", 32'(rsp_data), 32'(e_data));
            check("rsp_offset", 32'(rsp_offset), 32'(off));
            check("sat_data", 32'(s_data), 32'(e_data));
            check("sat_offset", 32'(s_offset), 32'(off));
        end
        if (!rst_n) begin
            check("rst_ram_addr", 32'(ram_addr), 32'h0);
            check("rst_rsp_data", 32'(rsp_data), 32'h0);
            check("rst_rsp_offset", 32'(rsp_offset), 32'h0);
        end

        if (act && d == N + L + 1) begin
            if (mcount < 65535) mcount++;
            act = 1'b0;
        end

        rst_n     = r;
        req_valid = v;
        req_addr  = a;
        if (!r) begin
            act    = 1'b0;
            mcount = 0;
        end else if (e_ready && v) begin
            act  = 1'b1;
            c0   = cyc;
            base = a & 16'hFFFC;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; ram_rdata = '0;
        for (int k = 0; k <= L; k++) hist[k] = '0;

        repeat (3) step(1'b0, 16'h0, 1'b0);
        check("reset_ready", 32'(req_ready), 32'h1);
        check("reset_count", 32'(refill_count), 32'h0);
        repeat (2) step(1'b0, 16'h0, 1'b1);

        // Refill of 9, with a second request for 16 held throughout.
        step(1'b1, 16'd9, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            step(j <= 15, 16'd16, 1'b1);
            case (j)
                1:  begin check("lit_addr_c1", 32'(ram_addr), 32'd8);
                          check("lit_ready_c1", 32'(req_ready), 32'h0); end
                4:  begin check("lit_addr_c4", 32'(ram_addr), 32'd11);
                          check("lit_data_c4", 32'(rsp_data), 32'hAD); end
                5:  check("lit_data_c5", 32'(rsp_data), 32'hAC);
                6:  check("lit_data_c6", 32'(rsp_data), 32'hAF);
                7:  begin check("lit_data_c7", 32'(rsp_data), 32'hAE);
                          check("lit_last_c7", 32'(rsp_last), 32'h1);
                          check("lit_en_c7", 32'(ram_en), 32'h0); end
                8:  begin check("lit_ready_c8", 32'(req_ready), 32'h1);
                          check("lit_count_c8", 32'(refill_count), 32'd1); end
                9:  check("lit_addr_c9", 32'(ram_addr), 32'd16);
                12: check("lit_data_c12", 32'(rsp_data), 32'hB5);
                15: begin check("lit_data_c15", 32'(rsp_data), 32'hB6);
                          check("lit_last_c15", 32'(rsp_last), 32'h1); end
                16: check("lit_count_c16", 32'(refill_count), 32'd2);
                default: ;
            endcase
        end

        // Reset in c3 of a refill of address 0.
        step(1'b1, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b0);
        #1;
        check("lit_abort_en", 32'(ram_en), 32'h0);
        check("lit_abort_ready", 32'(req_ready), 32'h1);
        check("lit_abort_count", 32'(refill_count), 32'h0);
        step(1'b0, 16'd0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 16'd0, 1'b1);
            check("lit_post_abort_valid", 32'(rsp_valid), 32'h0);
        end
        check("lit_post_abort_count", 32'(refill_count), 32'h0);
        step(1'b1, 16'd4, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 16'd0, 1'b1);
            if (j == 4) check("lit_data_a4", 32'(rsp_data), 32'hA1);
            if (j == 7) check("lit_data_a7", 32'(rsp_data), 32'hA2);
            if (j == 8) check("lit_count_a8", 32'(refill_count), 32'd1);
        end

        // Top of address space: no wrap inside the block.
        step(1'b1, 16'hFFFF, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 16'd0, 1'b1);
            if (j == 1) check("lit_addr_top1", 32'(ram_addr), 32'hFFFC);
            if (j == 4) check("lit_addr_top4", 32'(ram_addr), 32'hFFFF);
            if (j == 7) check("lit_data_top7", 32'(rsp_data), 32'h5A);
        end

        // Five refills: the 2-bit counter must stop at 3.
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 16'($urandom), 1'b1);
            repeat (7) step(1'b0, 16'd0, 1'b1);
        end
        repeat (2) step(1'b0, 16'd0, 1'b1);
        check("lit_count_7", 32'(refill_count), 32'd7);
        check("lit_sat_count", 32'(s_count), 32'd3);

        // Random traffic with occasional resets.
        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 299) != 0);
        end
        repeat (12) step(1'b0, 16'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
